// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, word type and scheduler state encoding.
// No ports; imported by the message scheduler files.
package sha256_pkg;
   localparam int SHA256_WORD_W  = 32;
   localparam int SHA256_BLOCK_W = 512;
   localparam int SHA256_ROUNDS  = 64;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_READY = 3'd2;
   localparam logic [2:0] ST_CALC1 = 3'd3;
   localparam logic [2:0] ST_CALC2 = 3'd4;
   localparam logic [2:0] ST_CALC3 = 3'd5;
   localparam logic [2:0] ST_WRITE = 3'd6;
   localparam logic [2:0] ST_DONE  = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_LOAD  = ST_LOAD,
      S_READY = ST_READY,
      S_CALC1 = ST_CALC1,
      S_CALC2 = ST_CALC2,
      S_CALC3 = ST_CALC3,
      S_WRITE = ST_WRITE,
      S_DONE  = ST_DONE
   } sched_state_t;

   typedef logic [SHA256_WORD_W-1:0] word_t;
endpackage

// File: rtl/message_scheduler_if.sv
// Scheduler bus: start/block_in/stn in, Wt_out/wt_valid/round_idx/busy/
// sched_done/sched_err out. master = compression side, slave = scheduler.
interface message_scheduler_if;
   import sha256_pkg::*;

   logic                      start;
   logic [SHA256_BLOCK_W-1:0] block_in;
   logic                      stn;
   word_t                     Wt_out;
   logic                      wt_valid;
   logic [5:0]                round_idx;
   logic                      busy;
   logic                      sched_done;
   logic                      sched_err;

   modport master (
      output start, block_in, stn,
      input  Wt_out, wt_valid, round_idx, busy, sched_done, sched_err
   );

   modport slave (
      input  start, block_in, stn,
      output Wt_out, wt_valid, round_idx, busy, sched_done, sched_err
   );
endinterface

// File: rtl/adder_32bit.sv
// Shared 32-bit modulo-2^32 adder.
// Ports: a, b (in, 32), sum (out, 32); carry out is dropped.
module adder_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);
   assign sum = a + b;
endmodule

// File: rtl/sigma_func_schedule.sv
// SHA-256 schedule small-sigma functions on one word.
// Ports: x (in, 32), s0 = sigma0(x) (out, 32), s1 = sigma1(x) (out, 32).
module sigma_func_schedule
   import sha256_pkg::*;
(
   input  word_t x,
   output word_t s0,
   output word_t s1
);
   assign s0 = {x[6:0], x[31:7]}
             ^ {x[17:0], x[31:18]}
             ^ (x >> 3);
   assign s1 = {x[16:0], x[31:17]}
             ^ {x[18:0], x[31:19]}
             ^ (x >> 10);
endmodule

// File: rtl/message_scheduler.sv
// SHA-256 message schedule W0..W63, one word per stn rise, 16-word ring.
// Ports: clk, rst_n (async low), bus (message_scheduler_if.slave).
// Optional overrun flag on sched_err when SCHED_ERR_CHK_EN is defined.
module message_scheduler
   import sha256_pkg::*;
#(
   parameter int NUM_ROUNDS = SHA256_ROUNDS
) (
   input  logic                clk,
   input  logic                rst_n,
   message_scheduler_if.slave  bus
);
   localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);

   sched_state_t state;
   word_t        w [16];
   word_t        acc;
   word_t        wt;
   logic [5:0]   t;
   logic         stn_q;
   logic         wt_valid_r;
   logic         busy_r;
   logic         done_r;

   logic [5:0] n;
   logic [3:0] i2, i7, i15, i16;
   logic       rise;
   word_t      sig_x, s0, s1;
   word_t      add_a, add_b, add_sum;

   // n is the round being produced; ring indices are n-k mod 16
   assign n    = t + 6'd1;
   assign i2   = n[3:0] - 4'd2;
   assign i7   = n[3:0] - 4'd7;
   assign i15  = n[3:0] - 4'd15;
   assign i16  = n[3:0];
   assign rise = bus.stn & ~stn_q;

   assign sig_x = (state == S_CALC1) ? w[i2] : w[i15];

   sigma_func_schedule u_sig (
      .x  (sig_x),
      .s0 (s0),
      .s1 (s1)
   );

   always_comb begin
      add_a = acc;
      add_b = w[i16];
      unique case (1'b1)
         state == S_CALC1: begin
            add_a = s1;
            add_b = w[i7];
         end
         state == S_CALC2: begin
            add_a = acc;
            add_b = s0;
         end
         default: begin
            add_a = acc;
            add_b = w[i16];
         end
      endcase
   end

   adder_32bit u_add (
      .a   (add_a),
      .b   (add_b),
      .sum (add_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         for (int i = 0; i < 16; i++) w[i] <= '0;
         acc        <= '0;
         wt         <= '0;
         t          <= '0;
         stn_q      <= 1'b0;
         wt_valid_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         stn_q  <= bus.stn;
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < 16; i++)
                     w[i] <= bus.block_in[SHA256_BLOCK_W-1-32*i -: 32];
                  busy_r <= 1'b1;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               wt         <= w[0];
               t          <= '0;
               wt_valid_r <= 1'b1;
               state      <= S_READY;
            end
            S_READY: begin
               if (rise) begin
                  if (t == LAST) begin
                     wt_valid_r <= 1'b0;
                     state      <= S_DONE;
                  end else if (n < 6'd16) begin
                     wt <= w[n[3:0]];
                     t  <= n;
                  end else begin
                     wt_valid_r <= 1'b0;
                     state      <= S_CALC1;
                  end
               end
            end
            S_CALC1: begin
               acc   <= add_sum;
               state <= S_CALC2;
            end
            S_CALC2: begin
               acc   <= add_sum;
               state <= S_CALC3;
            end
            S_CALC3: begin
               acc   <= add_sum;
               state <= S_WRITE;
            end
            S_WRITE: begin
               w[i16]     <= acc;
               wt         <= acc;
               t          <= n;
               wt_valid_r <= 1'b1;
               state      <= S_READY;
            end
            S_DONE: begin
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SCHED_ERR_CHK_EN
   logic err_r;

   // a rise while the current word is not on offer is lost
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_r <= 1'b0;
      else if (state == S_IDLE && bus.start)
         err_r <= 1'b0;
      else if (rise && (state == S_LOAD  || state == S_CALC1 ||
                        state == S_CALC2 || state == S_CALC3 ||
                        state == S_WRITE))
         err_r <= 1'b1;
   end

   assign bus.sched_err = err_r;
`else
   assign bus.sched_err = 1'b0;
`endif

   assign bus.Wt_out     = wt;
   assign bus.wt_valid   = wt_valid_r;
   assign bus.round_idx  = t;
   assign bus.busy       = busy_r;
   assign bus.sched_done = done_r;
endmodule

// File: tb/tb_message_scheduler.sv
// Randomized bench for message_scheduler against a full-array schedule model.
// Drives start/block_in/stn on negedges and samples outputs on negedges.
module tb_message_scheduler;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   bit   err_exp;
   logic [31:0] exp_w [64];

   message_scheduler_if bus ();

   message_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
      return (x >> s) | (x << (32 - s));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic compute_model(input logic [511:0] blk);
      for (int i = 0; i < 64; i++) begin
         if (i < 16)
            exp_w[i] = blk[511-32*i -: 32];
         else
            exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7]
                     + ssig0(exp_w[i-15]) + exp_w[i-16];
      end
   endtask

   function automatic logic [511:0] rnd_blk();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
      return b;
   endfunction

   task automatic do_start(input logic [511:0] blk);
      @(negedge clk);
      bus.block_in = blk;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
   endtask

   // stn held high for two cycles: must count as a single rise
   task automatic pulse_stn();
      @(negedge clk);
      bus.stn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.stn = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.wt_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("valid_timeout", 0, 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wt"},   bus.Wt_out,     0);
      chk({tag, "_vld"},  bus.wt_valid,   0);
      chk({tag, "_idx"},  bus.round_idx,  0);
      chk({tag, "_busy"}, bus.busy,       0);
      chk({tag, "_done"}, bus.sched_done, 0);
      chk({tag, "_err"},  bus.sched_err,  0);
   endtask

   task automatic run_block(input logic [511:0] blk, input bit abc,
                            input int ovr_at, input int mid_at,
                            input int rst_at);
      bit ok;
      bit seen;
      compute_model(blk);
      do_start(blk);
      err_exp = 1'b0;
      chk("start_err_clr", bus.sched_err, 0);
      chk("start_busy", bus.busy, 1);
      for (int k = 0; k < 64; k++) begin
         wait_valid(ok);
         if (!ok) return;
         repeat ($urandom_range(0, 5)) @(negedge clk);
         chk($sformatf("w%0d", k), bus.Wt_out, exp_w[k]);
         chk($sformatf("idx%0d", k), bus.round_idx, k);
         if (abc) begin
            if (k == 0)  chk("abc_w0",  bus.Wt_out, 32'h61626380);
            if (k == 14) chk("abc_w14", bus.Wt_out, 32'h00000000);
            if (k == 15) chk("abc_w15", bus.Wt_out, 32'h00000018);
            if (k == 16) chk("abc_w16", bus.Wt_out, 32'h61626380);
            if (k == 17) chk("abc_w17", bus.Wt_out, 32'h000F0000);
         end
         if (k == 63) chk("done_early", bus.sched_done, 0);
         if (k == mid_at) begin
            do_start(rnd_blk());
            chk("mid_idx", bus.round_idx, k);
            chk("mid_wt", bus.Wt_out, exp_w[k]);
            chk("mid_err", bus.sched_err, err_exp);
         end
         if (k == rst_at) begin
            @(negedge clk);
            bus.stn = 1'b1;
            @(negedge clk);
            @(negedge clk);
            bus.stn = 1'b0;
            rst_n = 1'b0;
            #1;
            chk_all_zero("rst_mid");
            @(negedge clk);
            chk_all_zero("rst_hold");
            rst_n = 1'b1;
            err_exp = 1'b0;
            return;
         end else if (k == ovr_at) begin
            @(negedge clk);
            bus.stn = 1'b1;
            @(negedge clk);
            bus.stn = 1'b0;
            @(negedge clk);
            bus.stn = 1'b1;
            @(negedge clk);
            bus.stn = 1'b0;
            @(negedge clk);
`ifdef SCHED_ERR_CHK_EN
            err_exp = 1'b1;
`endif
            chk("ovr_err", bus.sched_err, err_exp);
         end else begin
            pulse_stn();
         end
      end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.sched_done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("done_seen", seen, 1);
      chk("done_busy", bus.busy, 0);
      @(negedge clk);
      chk("done_pulse", bus.sched_done, 0);
      chk("end_err", bus.sched_err, err_exp);
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      err_exp      = 1'b0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.stn      = 1'b0;
      bus.block_in = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      // stn while idle must be ignored
      pulse_stn();
      chk("idle_stn_busy", bus.busy, 0);
      chk("idle_stn_vld", bus.wt_valid, 0);

      run_block({32'h61626380, {14{32'h0}}, 32'h18}, 1'b1, -1, -1, -1);
      run_block(rnd_blk(), 1'b0, 18, 30, -1);
      run_block(rnd_blk(), 1'b0, -1, -1, 20);
      run_block('0, 1'b0, -1, -1, -1);
      run_block(rnd_blk(), 1'b0, -1, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
